// File: rtl/pwm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : pwm_pkg                                                         |
// | Brief    : Shared state encoding and default sizes for duty_pwm_seq.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package pwm_pkg;

  localparam int c_DEFAULT_WIDTH = 16;
  localparam int c_DEFAULT_DEPTH = 4;

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_RUN  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/duty_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : duty_fifo                                                       |
// | Brief    : Synchronous duty-value FIFO with occupancy count and ready.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module duty_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_fill,
  output logic                       o_ready
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_FW = $clog2(DEPTH+1);
  localparam logic [c_FW-1:0] c_FULL = c_FW'(DEPTH);

  logic [WIDTH-1:0] r_mem_q [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr_q, w_wr_ptr_d;
  logic [c_AW-1:0]  r_rd_ptr_q, w_rd_ptr_d;
  logic [c_FW-1:0]  r_fill_q,   w_fill_d;
  logic             w_do_push, w_do_pop;

  // DEPTH is a power of two, so the pointers wrap on their own.
  assign w_do_push = i_push && (r_fill_q != c_FULL);
  assign w_do_pop  = i_pop  && (r_fill_q != '0);

  always_comb begin
    w_wr_ptr_d = r_wr_ptr_q;
    w_rd_ptr_d = r_rd_ptr_q;
    w_fill_d   = r_fill_q;
    if (w_do_push) w_wr_ptr_d = r_wr_ptr_q + c_AW'(1);
    if (w_do_pop)  w_rd_ptr_d = r_rd_ptr_q + c_AW'(1);
    case ({w_do_push, w_do_pop})
      2'b10:   w_fill_d = r_fill_q + c_FW'(1);
      2'b01:   w_fill_d = r_fill_q - c_FW'(1);
      default: w_fill_d = r_fill_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr_q <= '0;
      r_rd_ptr_q <= '0;
      r_fill_q   <= '0;
    end else begin
      r_wr_ptr_q <= w_wr_ptr_d;
      r_rd_ptr_q <= w_rd_ptr_d;
      r_fill_q   <= w_fill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem_q[r_wr_ptr_q] <= i_data;
  end

  assign o_head  = r_mem_q[r_rd_ptr_q];
  assign o_fill  = r_fill_q;
  assign o_ready = (r_fill_q < c_FULL);

endmodule
`default_nettype wire

// File: rtl/duty_pwm_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : duty_pwm_seq                                                    |
// | Brief    : FIFO-fed PWM generator; duty changes only at period boundaries. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module duty_pwm_seq
  import pwm_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH,
  parameter int DEPTH = c_DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           duty_in,
  input  logic                       duty_valid,
  output logic                       duty_ready,
  output logic                       pwm_out,
  output logic                       period_start,
  output logic                       underrun,
  output logic [$clog2(DEPTH+1)-1:0] fill
);

  localparam int c_FW = $clog2(DEPTH+1);
  localparam logic [WIDTH-1:0] c_CNT_LAST = {WIDTH{1'b1}};

  logic [0:0]       r_state_q, w_state_d;
  logic [WIDTH-1:0] r_cnt_q,   w_cnt_d;
  logic [WIDTH-1:0] r_duty_q,  w_duty_d;
  logic             r_pwm_q,   w_pwm_d;
  logic             r_ps_q,    w_ps_d;
  logic             r_under_q, w_under_d;

  logic             w_push, w_pop, w_ready;
  logic [WIDTH-1:0] w_head;
  logic [c_FW-1:0]  w_fill;

  assign w_push = duty_valid && w_ready;

  duty_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (duty_in),
    .o_head  (w_head),
    .o_fill  (w_fill),
    .o_ready (w_ready)
  );

  always_comb begin
    w_state_d = r_state_q;
    w_cnt_d   = r_cnt_q;
    w_duty_d  = r_duty_q;
    w_under_d = r_under_q;
    w_pwm_d   = 1'b0;
    w_ps_d    = 1'b0;
    w_pop     = 1'b0;
    case (r_state_q)
      c_ST_IDLE: begin
        w_cnt_d = '0;
        if (w_fill != '0) begin
          w_pop     = 1'b1;
          w_duty_d  = w_head;
          w_state_d = c_ST_RUN;
        end
      end
      c_ST_RUN: begin
        w_pwm_d = (r_cnt_q < r_duty_q);
        w_ps_d  = (r_cnt_q == '0);
        w_cnt_d = r_cnt_q + WIDTH'(1);
        // A push landing on an empty-FIFO boundary is only visible next period.
        if (r_cnt_q == c_CNT_LAST) begin
          if (w_fill != '0) begin
            w_pop    = 1'b1;
            w_duty_d = w_head;
          end else begin
            w_under_d = 1'b1;
          end
        end
      end
      default: w_state_d = c_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= c_ST_IDLE;
      r_cnt_q   <= '0;
      r_duty_q  <= '0;
      r_pwm_q   <= 1'b0;
      r_ps_q    <= 1'b0;
      r_under_q <= 1'b0;
    end else begin
      r_state_q <= w_state_d;
      r_cnt_q   <= w_cnt_d;
      r_duty_q  <= w_duty_d;
      r_pwm_q   <= w_pwm_d;
      r_ps_q    <= w_ps_d;
      r_under_q <= w_under_d;
    end
  end

  assign duty_ready   = w_ready;
  assign pwm_out      = r_pwm_q;
  assign period_start = r_ps_q;
  assign underrun     = r_under_q;
  assign fill         = w_fill;

endmodule
`default_nettype wire

// File: tb/tb_duty_pwm_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_duty_pwm_seq                                                 |
// | Brief    : Self-checking bench for duty_pwm_seq (WIDTH=4, DEPTH=4).        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_duty_pwm_seq;

  localparam int W = 4;
  localparam int D = 4;
  localparam int PER = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] duty_in;
  logic         duty_valid;
  logic         duty_ready;
  logic         pwm_out;
  logic         period_start;
  logic         underrun;
  logic [2:0]   fill;

  always #5 clk = ~clk;

  duty_pwm_seq #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .duty_in      (duty_in),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .underrun     (underrun),
    .fill         (fill)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of pending duties plus position within the period.
  int m_q[$];
  bit m_known;
  bit m_run;
  int m_pos;
  int m_duty;
  bit m_under;
  bit m_pwm;
  bit m_ps;

  // Observed period statistics, gathered from the DUT outputs only.
  int per_obs[$];
  int per_len[$];
  int hi_cnt;
  bit in_per;
  int ps_cnt;
  int cyc;
  int last_ps;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int get_per(int i);
    return (i < per_obs.size()) ? per_obs[i] : -1;
  endfunction

  function automatic int get_len(int i);
    return (i < per_len.size()) ? per_len[i] : -1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_run   = 1'b0;
    m_pos   = 0;
    m_duty  = 0;
    m_under = 1'b0;
    m_pwm   = 1'b0;
    m_ps    = 1'b0;
    per_obs.delete();
    per_len.delete();
    hi_cnt  = 0;
    in_per  = 1'b0;
    ps_cnt  = 0;
    last_ps = 0;
  endtask

  task automatic step();
    bit push;
    int pv;
    if (m_known) begin
      chk("duty_ready", duty_ready, (m_q.size() < D));
      chk("fill", fill, m_q.size());
    end
    push = duty_valid && (m_q.size() < D);
    pv   = int'(duty_in);
    if (rst) begin
      model_reset();
    end else begin
      m_pwm = m_run && (m_pos < m_duty);
      m_ps  = m_run && (m_pos == 0);
      if (!m_run) begin
        if (m_q.size() > 0) begin
          m_duty = m_q.pop_front();
          m_run  = 1'b1;
          m_pos  = 0;
        end
      end else begin
        if (m_pos == PER - 1) begin
          if (m_q.size() > 0) m_duty = m_q.pop_front();
          else                m_under = 1'b1;
        end
        m_pos = (m_pos + 1) % PER;
      end
      if (push) m_q.push_back(pv);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (m_known) begin
      chk("pwm_out", pwm_out, m_pwm);
      chk("period_start", period_start, m_ps);
      chk("underrun", underrun, m_under);
    end
    if (rst) m_known = 1'b1;
    if (period_start === 1'b1) begin
      if (in_per) begin
        per_obs.push_back(hi_cnt);
        per_len.push_back(cyc - last_ps);
      end
      hi_cnt  = 0;
      in_per  = 1'b1;
      last_ps = cyc;
      ps_cnt++;
    end
    if (in_per && pwm_out === 1'b1) hi_cnt++;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    duty_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic idle(int n);
    duty_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic push_val(int v);
    bit acc;
    int k;
    acc = 1'b0;
    k   = 0;
    duty_valid = 1'b1;
    duty_in    = W'(v);
    while (!acc && k < 100) begin
      acc = (m_q.size() < D);
      step();
      k++;
    end
    duty_valid = 1'b0;
    if (!acc) chk("push_timeout", {31'd0, acc}, 32'd1);
  endtask

  task automatic wait_ps(int n, int budget);
    int k;
    k = 0;
    duty_valid = 1'b0;
    while (ps_cnt < n && k < budget) begin
      step();
      k++;
    end
    chk("wait_period_start", (ps_cnt >= n), 1);
  endtask

  task automatic wait_pos(int pos, bit need_empty, int budget);
    int k;
    k = 0;
    duty_valid = 1'b0;
    while (!(m_run && m_pos == pos && (!need_empty || m_q.size() == 0)) && k < budget) begin
      step();
      k++;
    end
    chk("wait_count", (k < budget), 1);
  endtask

  initial begin
    rst        = 1'b1;
    duty_valid = 1'b0;
    duty_in    = '0;
    m_known    = 1'b0;
    cyc        = 0;
    model_reset();

    // Reset state
    do_reset();
    chk("rst_ready", duty_ready, 1);
    chk("rst_fill", fill, 0);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_under", underrun, 0);
    idle(3);
    chk("idle_ps", period_start, 0);

    // Single duty 5: 5/16 high, 16-cycle periods, underrun at second boundary
    push_val(5);
    wait_ps(3, 80);
    chk("s1_p0", get_per(0), 5);
    chk("s1_p1", get_per(1), 5);
    chk("s1_len0", get_len(0), PER);
    chk("s1_len1", get_len(1), PER);
    chk("s1_under", underrun, 1);

    // Duty boundaries 0 and 15
    do_reset();
    push_val(0);
    push_val(15);
    push_val(15);
    wait_ps(3, 80);
    idle(10);
    chk("s2_no_under", underrun, 0);
    wait_ps(4, 40);
    chk("s2_p0", get_per(0), 0);
    chk("s2_p1", get_per(1), 15);
    chk("s2_p2", get_per(2), 15);
    chk("s2_under", underrun, 1);

    // Back-to-back pushes fill the FIFO; order is preserved
    do_reset();
    push_val(1);
    push_val(2);
    push_val(3);
    push_val(4);
    push_val(9);
    chk("s3_full_ready", duty_ready, 0);
    chk("s3_full_fill", fill, 4);
    wait_ps(6, 120);
    chk("s3_p0", get_per(0), 1);
    chk("s3_p1", get_per(1), 2);
    chk("s3_p2", get_per(2), 3);
    chk("s3_p3", get_per(3), 4);
    chk("s3_p4", get_per(4), 9);

    // Push on an empty-FIFO boundary is deferred one period
    do_reset();
    push_val(5);
    wait_pos(PER - 1, 1'b1, 60);
    duty_valid = 1'b1;
    duty_in    = W'(7);
    step();
    duty_valid = 1'b0;
    chk("s4_under", underrun, 1);
    chk("s4_fill", fill, 1);
    wait_ps(4, 80);
    chk("s4_p0", get_per(0), 5);
    chk("s4_p1", get_per(1), 5);
    chk("s4_p2", get_per(2), 7);

    // Mid-period reset discards FIFO contents
    do_reset();
    push_val(8);
    push_val(3);
    wait_pos(6, 1'b0, 40);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("s5_pwm", pwm_out, 0);
    chk("s5_fill", fill, 0);
    chk("s5_under", underrun, 0);
    chk("s5_ps", period_start, 0);
    idle(3);
    push_val(2);
    wait_ps(2, 60);
    chk("s5_p0", get_per(0), 2);

    // Randomized traffic against the model, with occasional resets
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      duty_valid = ($urandom_range(0, 15) < 3);
      duty_in    = W'($urandom_range(0, PER - 1));
      step();
    end
    rst = 1'b0;
    idle(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/duty_pwm_seq.md
DUTY_PWM_SEQ -- requirements
Module: duty_pwm_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the duty/counter width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, the duty FIFO depth in entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 duty_in  input  WIDTH  duty value from the summing stage, count of high cycles per period.
REQ-006 duty_valid  input  1  duty_in is valid this cycle.
REQ-007 duty_ready  output  1  FIFO can accept; a push occurs when duty_valid && duty_ready.
REQ-008 pwm_out  output  1  registered PWM output.
REQ-009 period_start  output  1  one-cycle pulse, high in the first output cycle of each period.
REQ-010 underrun  output  1  sticky flag, period boundary with empty FIFO.
REQ-011 fill  output  $clog2(DEPTH+1)  current FIFO occupancy.

Function
REQ-012 The state machine SHALL have two states: IDLE (after reset) and RUN.
REQ-013 In IDLE, the period counter SHALL be held at 0, and pwm_out and period_start SHALL be 0.
REQ-014 IDLE SHALL go to RUN on a cycle with fill>0: pop the head into the active duty register and start the counter at 0 on the next cycle.
REQ-015 In RUN, the counter SHALL run 0..2^WIDTH-1 and wrap to 0 (period = 2^WIDTH clocks).
REQ-016 At the last count (2^WIDTH-1) in RUN, the block SHALL pop the FIFO head into the active duty register if fill>0; otherwise it keeps the active duty and sets underrun.
REQ-017 pwm_out SHALL be registered as (counter < active duty), giving one cycle latency from the counter.
REQ-018 period_start SHALL be registered as (counter == 0 in RUN), aligned with pwm_out.
REQ-019 Duty boundary values: duty 0 SHALL give pwm_out low for the whole period; duty 2^WIDTH-1 SHALL give high for 2^WIDTH-1 cycles and low for 1 cycle.
REQ-020 A new duty SHALL take effect only at a period boundary, never mid-period.
REQ-021 duty_ready SHALL equal (fill < DEPTH) and is combinational from fill only; there is no full-FIFO bypass.
REQ-022 Simultaneous push and pop SHALL leave fill unchanged and preserve FIFO order.
REQ-023 A push in the same cycle as a boundary with empty FIFO SHALL NOT bypass; underrun is set and the value is used at the next boundary.
REQ-024 A push when full SHALL be impossible by handshake; duty_in SHALL be ignored when duty_ready is 0.
REQ-025 underrun SHALL clear only on rst.
REQ-026 The block SHALL never return from RUN to IDLE except by rst.

Reset
REQ-027 On rst, the state SHALL be IDLE, and counter, active duty, FIFO pointers, fill, pwm_out, period_start and underrun SHALL all be 0, with duty_ready 1.
REQ-028 rst asserted mid-period SHALL force pwm_out low on the following cycle and discard all FIFO contents.

Structure
REQ-029 The state enum (IDLE, RUN) and the default WIDTH/DEPTH constants SHALL live in a shared package, pwm_pkg.
REQ-030 The FIFO SHALL be a separate sub-module, duty_fifo (synchronous, with push/pop/fill and the same clk/rst).
REQ-031 Estimated size is 150-250 lines of RTL in total.

Verification (WIDTH=4, DEPTH=4)
REQ-032 Reset, then push 5 -> RUN; pwm_out is high 5 of every 16 cycles; period_start pulses every 16 cycles; underrun rises at the 2nd boundary.
REQ-033 Push 0, 15 and 15 back-to-back -> period 1 all low; periods 2 and 3 each 15 high then 1 low; no underrun through period 3.
REQ-034 Push 1,2,3,4,9 continuously in IDLE -> duty_ready drops after the FIFO fills; 9 is accepted after the first pop; periods show 1,2,3,4,9 in order.
REQ-035 Push 7 at the last count of a period with the FIFO empty -> underrun=1; the old duty repeats one period; 7 is applied the following period.
REQ-036 Push 8 and 3, then assert rst at count 6 of period 1 -> next cycle pwm_out=0, fill=0, underrun=0, IDLE; a post-reset push of 2 gives 2/16 high.
